// File: rtl/tx_fcs_append.sv
// Transmit byte-stream stage: forwards PSDU bytes unchanged, then appends the
// 802.11 CRC-32 FCS (LSB first), computed two nibbles per accepted byte.
module tx_fcs_append #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_done
);

  typedef enum logic [2:0] {PASS, FCS0, FCS1, FCS2, FCS3} state_t;

  state_t           state;
  logic [31:0]      crc;
  logic [31:0]      fcs;
  logic [31:0]      crc_lo;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_pend;
  logic             out_free;
  logic             out_take;
  logic             accept;

  // One reflected CRC-32 step over a nibble using the 16-entry table.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] nib);
    logic [31:0] t;
    case (c[3:0] ^ nib)
      4'h0:    t = 32'h00000000;
      4'h1:    t = 32'h1DB71064;
      4'h2:    t = 32'h3B6E20C8;
      4'h3:    t = 32'h26D930AC;
      4'h4:    t = 32'h76DC4190;
      4'h5:    t = 32'h6B6B51F4;
      4'h6:    t = 32'h4DB26158;
      4'h7:    t = 32'h5005713C;
      4'h8:    t = 32'hEDB88320;
      4'h9:    t = 32'hF00F9344;
      4'hA:    t = 32'hD6D6A3E8;
      4'hB:    t = 32'hCB61B38C;
      4'hC:    t = 32'h9B64C2B0;
      4'hD:    t = 32'h86D3D2D4;
      4'hE:    t = 32'hA00AE278;
      default: t = 32'hBDBDF21C;
    endcase
    return (c >> 4) ^ t;
  endfunction

  assign out_free = !m_valid || m_ready;
  assign out_take = m_valid && m_ready;
  assign s_ready  = (state == PASS) && out_free;
  assign accept   = s_valid && s_ready;
  assign crc_lo   = crc_nibble(crc, s_data[3:0]);
  assign crc_next = crc_nibble(crc_lo, s_data[7:4]);

  // frame_len is staged in len_pend so it changes together with frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      crc        <= 32'hFFFFFFFF;
      fcs        <= '0;
      count      <= '0;
      len_pend   <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_take && m_last;
      if (out_take && m_last)
        frame_len <= len_pend;
      if (out_take) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (accept)
        busy <= 1'b1;
      else if (out_take && m_last)
        busy <= 1'b0;

      case (state)
        PASS: begin
          if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_next;
            count   <= count + LEN_W'(1);
            if (s_last) begin
              fcs   <= ~crc_next;
              state <= FCS0;
            end
          end
        end
        FCS0: begin
          if (out_free) begin
            m_data  <= fcs[7:0];
            m_valid <= 1'b1;
            state   <= FCS1;
          end
        end
        FCS1: begin
          if (out_free) begin
            m_data  <= fcs[15:8];
            m_valid <= 1'b1;
            state   <= FCS2;
          end
        end
        FCS2: begin
          if (out_free) begin
            m_data  <= fcs[23:16];
            m_valid <= 1'b1;
            state   <= FCS3;
          end
        end
        FCS3: begin
          if (out_free) begin
            m_data   <= fcs[31:24];
            m_valid  <= 1'b1;
            m_last   <= 1'b1;
            crc      <= 32'hFFFFFFFF;
            len_pend <= count + LEN_W'(4);
            count    <= '0;
            state    <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fcs_append.sv
// Self-checking bench for tx_fcs_append: a queue-based reference model predicts
// every output byte, s_ready, busy, frame_done and frame_len each cycle.
module tb_tx_fcs_append;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_data = 8'h00;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic [LEN_W-1:0] frame_len;
  logic             frame_done;

  tx_fcs_append #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_len(frame_len), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // 0: always ready, 1: random ~50%, 2: driven directly by the main sequence
  int   ready_mode = 0;
  logic auto_ready = 1'b1;
  logic manual_ready = 1'b1;
  assign m_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? auto_ready : manual_ready;

  always @(posedge clk) begin
    #1;
    auto_ready = 1'($urandom_range(1));
  end

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_t;

  int          checks = 0;
  int          errors = 0;
  out_t        exp_q[$];
  int          len_q[$];
  logic [7:0]  cap_q[$];
  logic [31:0] run_crc = 32'hFFFFFFFF;
  int          run_count = 0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_len = 16'h0;
  bit          model_live = 1'b0;
  int          cyc = 0;
  int          first_hs = -1;
  int          last_hs = -1;
  int          done_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] model_fcs(input logic [7:0] bytes[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) c = crc_byte(c, bytes[i]);
    return ~c;
  endfunction

  function automatic out_t mk(input logic [7:0] d, input logic l);
    out_t o;
    o.data = d;
    o.last = l;
    return o;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    len_q.delete();
    run_crc   = 32'hFFFFFFFF;
    run_count = 0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_len   = 16'h0;
  endtask

  // Output bytes are owed in order; s_ready may only be high once at most the
  // byte sitting in the output register is still owed and it is leaving now.
  always @(negedge clk) begin : compare
    logic        exp_sready;
    logic        hs;
    logic        acc;
    logic        popped_last;
    logic [31:0] fcs;
    out_t        head;
    cyc++;
    if (!model_live) begin
      if (rst) begin
        model_reset();
        model_live = 1'b1;
      end
    end else begin
      exp_sready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
      checkOutput("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("m_data", 32'(m_data), 32'(exp_q[0].data));
        checkOutput("m_last", 32'(m_last), 32'(exp_q[0].last));
      end
      checkOutput("s_ready", 32'(s_ready), 32'(exp_sready));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
      checkOutput("frame_len", 32'(frame_len), 32'(exp_len));
      if (frame_done === 1'b1) done_count++;
      if (rst) begin
        model_reset();
      end else begin
        hs          = m_valid && m_ready;
        popped_last = 1'b0;
        exp_done    = 1'b0;
        if (hs && exp_q.size() != 0) begin
          head = exp_q.pop_front();
          cap_q.push_back(m_data);
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          if (head.last) begin
            popped_last = 1'b1;
            exp_done    = 1'b1;
            if (len_q.size() != 0) exp_len = 16'(len_q.pop_front());
          end
        end
        acc = s_valid && s_ready;
        if (acc) begin
          exp_q.push_back(mk(s_data, 1'b0));
          run_crc = crc_byte(run_crc, s_data);
          run_count++;
          if (s_last) begin
            fcs = ~run_crc;
            exp_q.push_back(mk(fcs[7:0], 1'b0));
            exp_q.push_back(mk(fcs[15:8], 1'b0));
            exp_q.push_back(mk(fcs[23:16], 1'b0));
            exp_q.push_back(mk(fcs[31:24], 1'b1));
            len_q.push_back((run_count + 4) % 65536);
            run_crc   = 32'hFFFFFFFF;
            run_count = 0;
          end
        end
        if (acc) exp_busy = 1'b1;
        else if (popped_last) exp_busy = 1'b0;
      end
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic applyStimulus(input logic [7:0] bytes[$], input bit with_last, input int gap_pct);
    bit acc;
    int waited;
    foreach (bytes[i]) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = bytes[i];
      s_last  = with_last && (i == bytes.size() - 1);
      acc     = 1'b0;
      waited  = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        waited++;
      end
      checkOutput("input_accept", 32'(acc), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || exp_busy) && n < 500);
    checkOutput("drain", 32'(exp_q.size() == 0 && !exp_busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    cap_q.delete();
    first_hs = -1;
    last_hs  = -1;
  endtask

  task automatic check_capture(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "_count"}, 32'(cap_q.size()), 32'(exp.size()));
    foreach (exp[i])
      checkOutput({name, "_byte"}, (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFFFFFF, 32'(exp[i]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] chk[$];
    logic [7:0] one[$];
    logic [7:0] part[$];
    logic [7:0] rnd[$];
    logic [7:0] exp[$];
    int d0;
    int n;

    chk  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one  = '{8'h00};
    part = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_m_data", 32'(m_data), 32'd0);
    checkOutput("reset_m_last", 32'(m_last), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_len", 32'(frame_len), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    checkOutput("model_fcs_check_string", model_fcs(chk), 32'hCBF43926);
    checkOutput("model_fcs_zero_byte", model_fcs(one), 32'hD202EF8D);

    // check string, continuous ready
    @(posedge clk); #1;
    clear_capture();
    d0 = done_count;
    applyStimulus(chk, 1'b1, 0);
    wait_drain();
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    check_capture("check_string", exp);
    checkOutput("check_string_len", 32'(frame_len), 32'd13);
    checkOutput("check_string_busy_after", 32'(busy), 32'd0);
    checkOutput("check_string_done_pulses", 32'(done_count - d0), 32'd1);

    // single zero byte
    clear_capture();
    d0 = done_count;
    applyStimulus(one, 1'b1, 0);
    wait_drain();
    exp = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    check_capture("single_byte", exp);
    checkOutput("single_byte_len", 32'(frame_len), 32'd5);
    checkOutput("single_byte_done_pulses", 32'(done_count - d0), 32'd1);

    // backpressure on the check string
    ready_mode = 1;
    clear_capture();
    applyStimulus(chk, 1'b1, 0);
    wait_drain();
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    check_capture("backpressure", exp);

    // back-to-back frames with s_valid held high
    ready_mode = 0;
    @(posedge clk); #1;
    clear_capture();
    applyStimulus(chk, 1'b1, 0);
    applyStimulus(one, 1'b1, 0);
    wait_drain();
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB, 8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    check_capture("back_to_back", exp);
    checkOutput("back_to_back_span", 32'(last_hs - first_hs), 32'd17);
    checkOutput("back_to_back_len", 32'(frame_len), 32'd5);

    // random frames, random gaps and backpressure
    ready_mode = 1;
    d0 = done_count;
    for (int f = 0; f < 10; f++) begin
      rnd.delete();
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) rnd.push_back(8'($urandom));
      applyStimulus(rnd, 1'b1, 30);
    end
    wait_drain();
    checkOutput("random_done_pulses", 32'(done_count - d0), 32'd10);

    // reset in the middle of a payload
    ready_mode = 0;
    applyStimulus(part, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_frame_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_mid_frame_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_frame_m_data", 32'(m_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_capture();
    applyStimulus(chk, 1'b1, 0);
    wait_drain();
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    check_capture("after_rst_mid_frame", exp);

    // reset while the third FCS byte is still owed, output stalled
    manual_ready = 1'b1;
    ready_mode   = 2;
    applyStimulus(one, 1'b1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    manual_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_fcs_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_mid_fcs_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_mid_fcs_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    clear_capture();
    applyStimulus(one, 1'b1, 0);
    wait_drain();
    exp = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    check_capture("after_rst_mid_fcs", exp);
    checkOutput("after_rst_mid_fcs_len", 32'(frame_len), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
